// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - access-size/lane constants and lane merge/extract helpers for reg_bank_rw
package reg_bank_pkg;

  typedef enum logic {SIZE_BYTE = 1'b0, SIZE_WORD = 1'b1} size_e;
  typedef enum logic {LANE_LO = 1'b0, LANE_HI = 1'b1} lane_e;

  // Helpers work on a wide container so any even DATA_W up to MAX_W shares them.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] lane_word_t;

  function automatic lane_word_t half_mask(input int unsigned w, input logic hi);
    lane_word_t lo_m;
    lo_m = (lane_word_t'(1) << (w / 2)) - lane_word_t'(1);
    return hi ? (lo_m << (w / 2)) : lo_m;
  endfunction

  function automatic lane_word_t lane_merge(input lane_word_t old_v, input lane_word_t new_v,
                                            input logic size, input logic hi,
                                            input int unsigned w);
    lane_word_t m;
    m = half_mask(w, hi);
    return (size == SIZE_WORD) ? new_v : ((old_v & ~m) | (new_v & m));
  endfunction

  // Byte reads keep the lane in place and zero the other half.
  function automatic lane_word_t lane_extract(input lane_word_t val, input logic size,
                                              input logic hi, input int unsigned w);
    return (size == SIZE_WORD) ? val : (val & half_mask(w, hi));
  endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// rtl/reg_bank_rd_port.sv - one registered read port: select, legality check, lane extract
module reg_bank_rd_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int BYTE_REGS = 4,
  parameter int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_sel,
  input  logic                       rd_size,
  input  logic                       rd_hi,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       illegal
);

  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              legal;

  assign sel_val = regs_flat[int'(rd_sel)*DATA_W +: DATA_W];
  assign legal   = (rd_size == SIZE_WORD) || ({1'b0, rd_sel} < (ADDR_W+1)'(BYTE_REGS));
  assign illegal = rd_en & ~legal;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data_d = legal ? DATA_W'(lane_extract(MAX_W'(sel_val), rd_size, rd_hi, DATA_W))
                        : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_bank_rw.sv
// rtl/reg_bank_rw.sv - register bank, one write port and NUM_RD read ports, byte lanes on low regs
// Optional REG_BANK_BYPASS_EN: same-cycle write-to-read forwarding of legal writes.
module reg_bank_rw
  import reg_bank_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_REGS  = 8,
  parameter  int NUM_RD    = 2,
  parameter  int BYTE_REGS = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_sel,
  input  logic                     wr_size,
  input  logic                     wr_hi,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  input  logic [NUM_RD-1:0]        rd_size,
  input  logic [NUM_RD-1:0]        rd_hi,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     err,
  input  logic                     err_clr
);

  logic [DATA_W-1:0]          reg_q [NUM_REGS];
  logic [DATA_W-1:0]          reg_d [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] view_flat;
  logic [NUM_RD-1:0]          rd_illegal;
  logic                       wr_legal, wr_illegal;
  logic                       err_d, err_q;

  assign wr_legal   = (wr_size == SIZE_WORD) || ({1'b0, wr_sel} < (ADDR_W+1)'(BYTE_REGS));
  assign wr_illegal = wr_en & ~wr_legal;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_d[i] = reg_q[i];
    if (wr_en && wr_legal) begin
      reg_d[wr_sel] = DATA_W'(lane_merge(MAX_W'(reg_q[wr_sel]), MAX_W'(wr_data),
                                         wr_size, wr_hi, DATA_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= reg_d[i];
    end
  end

  // reg_d already holds the merged post-write value and ignores illegal writes.
  always_comb begin
    view_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REG_BANK_BYPASS_EN
      view_flat[i*DATA_W +: DATA_W] = reg_d[i];
`else
      view_flat[i*DATA_W +: DATA_W] = reg_q[i];
`endif
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_bank_rd_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .BYTE_REGS(BYTE_REGS),
      .ADDR_W   (ADDR_W)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[k]),
      .rd_sel   (rd_sel[k*ADDR_W +: ADDR_W]),
      .rd_size  (rd_size[k]),
      .rd_hi    (rd_hi[k]),
      .regs_flat(view_flat),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[k]),
      .illegal  (rd_illegal[k])
    );
  end

  // Set has priority over clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (wr_illegal || (|rd_illegal)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_bank_rw.sv
// tb/tb_reg_bank_rw.sv - self-checking bench for reg_bank_rw with an arithmetic reference model
module tb_reg_bank_rw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_sel = '0;
  logic        wr_size = 1'b0;
  logic        wr_hi = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [5:0]  rd_sel = '0;
  logic [1:0]  rd_size = '0;
  logic [1:0]  rd_hi = '0;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic        err;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] model [8];
  logic [15:0] exp_data [2];
  logic [1:0]  exp_valid;
  logic        exp_err;

  reg_bank_rw dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_size(wr_size),
    .wr_hi(wr_hi), .wr_data(wr_data), .rd_en(rd_en), .rd_sel(rd_sel), .rd_size(rd_size),
    .rd_hi(rd_hi), .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus cycle: drive, predict from the model, clock, leave outputs ready to sample.
  task automatic step(input logic we, input logic [2:0] ws, input logic wsz, input logic whi,
                      input logic [15:0] wd, input logic [1:0] re, input logic [2:0] rs0,
                      input logic [2:0] rs1, input logic [1:0] rsz, input logic [1:0] rhi,
                      input logic ec);
    int          oldv, newi, src;
    logic        wlegal, ill;
    logic [2:0]  rs;
    wr_en = we; wr_sel = ws; wr_size = wsz; wr_hi = whi; wr_data = wd;
    rd_en = re; rd_sel = {rs1, rs0}; rd_size = rsz; rd_hi = rhi; err_clr = ec;
    wlegal = wsz || (ws < 3'd4);
    ill = we && !wlegal;
    oldv = int'(model[ws]);
    if (wsz)      newi = int'(wd);
    else if (whi) newi = (int'(wd) / 256) * 256 + oldv % 256;
    else          newi = (oldv / 256) * 256 + int'(wd) % 256;
    for (int k = 0; k < 2; k++) begin
      rs = (k == 1) ? rs1 : rs0;
      if (re[k]) begin
        src = int'(model[rs]);
`ifdef REG_BANK_BYPASS_EN
        if (we && wlegal && rs == ws) src = newi;
`endif
        if (!rsz[k] && rs >= 3'd4) begin
          exp_data[k] = 16'h0;
          ill = 1'b1;
        end else if (rsz[k]) exp_data[k] = 16'(src);
        else if (rhi[k])     exp_data[k] = 16'((src / 256) * 256);
        else                 exp_data[k] = 16'(src % 256);
        exp_valid[k] = 1'b1;
      end else begin
        exp_valid[k] = 1'b0;
      end
    end
    if (ec)  exp_err = 1'b0;
    if (ill) exp_err = 1'b1;
    if (we && wlegal) model[ws] = 16'(newi);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = '0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_data[0] = '0; exp_data[1] = '0; exp_valid = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1, 3'd0, 1, 0, 16'h7777, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(0, 3'd0, 0, 0, 16'h0, 2'b11, 3'd0, 3'd7, 2'b01, 2'b00, 0);
    total++;
    if (rd_data[15:0] !== 16'h7777 || err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: data0=%h err=%b expected data0=7777 err=1", rd_data[15:0], err);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (rd_data !== 32'h0 || rd_valid !== 2'b00 || err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: data=%h valid=%b err=%b expected all 0", rd_data, rd_valid, err);
    end
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_data[0] = '0; exp_data[1] = '0; exp_valid = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int r = 0; r < 8; r += 2) begin
      step(0, 3'd0, 0, 0, 16'h0, 2'b11, 3'(r), 3'(r + 1), 2'b11, 2'b00, 0);
      total++;
      if (rd_data !== 32'h0 || rd_valid !== 2'b11) begin
        bad++;
        $display("FAIL reset_regs r%0d/r%0d: data=%h valid=%b expected 0 and 11",
                 r, r + 1, rd_data, rd_valid);
      end
    end
  endtask

  task automatic test_word_rw;
    step(1, 3'd3, 1, 0, 16'hBEEF, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(0, 3'd0, 0, 0, 16'h0, 2'b01, 3'd3, 3'd0, 2'b01, 2'b00, 0);
    total++;
    if (rd_data[15:0] !== 16'hBEEF || rd_valid !== 2'b01) begin
      bad++;
      $display("FAIL word_read: data0=%h valid=%b expected BEEF 01", rd_data[15:0], rd_valid);
    end
    step(0, 3'd0, 0, 0, 16'h0, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    total++;
    if (rd_data[15:0] !== 16'hBEEF || rd_valid !== 2'b00) begin
      bad++;
      $display("FAIL read_hold: data0=%h valid=%b expected BEEF 00", rd_data[15:0], rd_valid);
    end
  endtask

  task automatic test_byte_lanes;
    step(1, 3'd1, 1, 0, 16'h1234, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(1, 3'd1, 0, 1, 16'hAB00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(0, 3'd0, 0, 0, 16'h0, 2'b11, 3'd1, 3'd1, 2'b01, 2'b10, 0);
    total++;
    if (rd_data[31:16] !== 16'hAB00 || rd_data[15:0] !== 16'hAB34) begin
      bad++;
      $display("FAIL byte_hi: data1=%h data0=%h expected AB00 AB34", rd_data[31:16], rd_data[15:0]);
    end
    step(0, 3'd0, 0, 0, 16'h0, 2'b10, 3'd0, 3'd1, 2'b00, 2'b00, 0);
    total++;
    if (rd_data[31:16] !== 16'h0034 || rd_valid !== 2'b10) begin
      bad++;
      $display("FAIL byte_lo: data1=%h valid=%b expected 0034 10", rd_data[31:16], rd_valid);
    end
  endtask

  task automatic test_err;
    step(1, 3'd5, 0, 1, 16'hFFFF, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL illegal_write_err: err=%b expected 1", err);
    end
    step(0, 3'd0, 0, 0, 16'h0, 2'b01, 3'd5, 3'd0, 2'b01, 2'b00, 0);
    total++;
    if (rd_data[15:0] !== 16'h0000) begin
      bad++;
      $display("FAIL reg5_unchanged: data0=%h expected 0000", rd_data[15:0]);
    end
    step(0, 3'd0, 0, 0, 16'h0, 2'b01, 3'd6, 3'd0, 2'b00, 2'b00, 1);
    total++;
    if (err !== 1'b1 || rd_data[15:0] !== 16'h0 || rd_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL set_beats_clear: err=%b data0=%h valid0=%b expected 1 0000 1",
               err, rd_data[15:0], rd_valid[0]);
    end
    step(0, 3'd0, 0, 0, 16'h0, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b expected 0", err);
    end
  endtask

  task automatic test_same_cycle;
    logic [15:0] want;
    step(1, 3'd0, 1, 0, 16'h5A5A, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(1, 3'd2, 1, 0, 16'h1111, 2'b00, 3'd0, 3'd0, 2'b00, 2'b00, 0);
    step(1, 3'd2, 1, 0, 16'h2222, 2'b11, 3'd2, 3'd0, 2'b11, 2'b00, 0);
`ifdef REG_BANK_BYPASS_EN
    want = 16'h2222;
`else
    want = 16'h1111;
`endif
    total++;
    if (rd_data[15:0] !== want || rd_data[31:16] !== 16'h5A5A) begin
      bad++;
      $display("FAIL same_cycle_word: data0=%h data1=%h expected %h 5A5A",
               rd_data[15:0], rd_data[31:16], want);
    end
    step(1, 3'd2, 0, 0, 16'h00CD, 2'b10, 3'd0, 3'd2, 2'b10, 2'b00, 0);
`ifdef REG_BANK_BYPASS_EN
    want = 16'h22CD;
`else
    want = 16'h2222;
`endif
    total++;
    if (rd_data[31:16] !== want) begin
      bad++;
      $display("FAIL same_cycle_byte: data1=%h expected %h", rd_data[31:16], want);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 16'($urandom),
           2'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_data[k*16 +: 16] !== exp_data[k] || rd_valid[k] !== exp_valid[k]) begin
          bad++;
          $display("FAIL random[%0d] port%0d: data=%h valid=%b expected %h %b",
                   n, k, rd_data[k*16 +: 16], rd_valid[k], exp_data[k], exp_valid[k]);
        end
      end
      total++;
      if (err !== exp_err) begin
        bad++;
        $display("FAIL random[%0d] err: err=%b expected %b", n, err, exp_err);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_rw;
    test_byte_lanes;
    test_err;
    test_same_cycle;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
